// File: rtl/muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_pkg
//   Shared encodings for the EX-stage multiply/divide controller:
//   HI/LO-class operation codes, FSM state encoding, counter width and
//   small op-classification helpers.
// -----------------------------------------------------------------------------
package muldiv_ctrl_pkg;

   // Operation select as decoded by EX; codes 000 and 111 are ignored.
   typedef enum logic [2:0] {
      OP_NONE  = 3'b000,
      OP_MULT  = 3'b001,
      OP_MULTU = 3'b010,
      OP_DIV   = 3'b011,
      OP_DIVU  = 3'b100,
      OP_MTHI  = 3'b101,
      OP_MTLO  = 3'b110
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL_WAIT = 2'd1,
      ST_DIV_WAIT = 2'd2,
      ST_DONE     = 2'd3
   } state_e;

   // Wide enough for MUL_LAT-1 with MUL_LAT up to 15.
   localparam int unsigned CNT_W = 4;

   function automatic logic is_mul_op(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_ctrl_hilo_reg.sv
// -----------------------------------------------------------------------------
// hilo_reg
//   Architectural HI and LO registers with independent write enables.
//   Ports:
//     clk, resetn      clock, asynchronous active-low reset
//     we_hi, we_lo     write enables for HI and LO
//     hi_i, lo_i       write data
//     hi_o, lo_o       registered HI/LO values (no write bypass)
// -----------------------------------------------------------------------------
module hilo_reg (
   input  logic        clk,
   input  logic        resetn,
   input  logic        we_hi,
   input  logic        we_lo,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   logic [31:0] hi_d, hi_q;
   logic [31:0] lo_d, lo_q;

   always_comb begin
      hi_d = we_hi ? hi_i : hi_q;
      lo_d = we_lo ? lo_i : lo_q;
   end

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values; blocking assignments here would create ordering races.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//   EX-stage sequencer for the pipelined multiplier and iterative divider.
//   Issues the decoded HI/LO-class op, stalls EX until the result is written
//   to HI/LO, and parks in DONE until EX is free to advance so the same
//   instruction is never issued twice.
//   Ports:
//     clk, resetn                 clock, asynchronous active-low reset
//     flush                       abort in-flight op, no HI/LO write
//     pipe_hold                   EX held by another stall source
//     op_valid, op_code           decoded op from EX (stable while stalled)
//     src_a, src_b                rs / rt operands
//     stallreq, busy              EX stall request, FSM not idle
//     hi_o, lo_o                  architectural HI / LO
//     mul_signed, mul_ina/inb     multiplier controls (valid in MUL_WAIT)
//     mul_result                  product, MUL_LAT cycles after operands
//     div_start, div_signed,
//     div_op1/op2, div_annul      divider controls (valid in DIV_WAIT)
//     div_result, div_ready       {remainder, quotient} and its valid
// -----------------------------------------------------------------------------
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int unsigned MUL_LAT = 2   // legal range 1..15
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        flush,
   input  logic        pipe_hold,
   input  logic        op_valid,
   input  logic [2:0]  op_code,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        stallreq,
   output logic        busy,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        mul_signed,
   output logic [31:0] mul_ina,
   output logic [31:0] mul_inb,
   input  logic [63:0] mul_result,
   output logic        div_start,
   output logic        div_signed,
   output logic [31:0] div_op1,
   output logic [31:0] div_op2,
   output logic        div_annul,
   input  logic [63:0] div_result,
   input  logic        div_ready
);

   state_e            state_d, state_q;
   logic [31:0]       opa_d, opa_q;
   logic [31:0]       opb_d, opb_q;
   logic              sgn_d, sgn_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;

   logic              we_hi, we_lo;
   logic [31:0]       hi_wr, lo_wr;

   logic              in_idle, in_mul, in_div;

   assign in_idle = (state_q == ST_IDLE);
   assign in_mul  = (state_q == ST_MUL_WAIT);
   assign in_div  = (state_q == ST_DIV_WAIT);

   // Next-state, operand latch and HI/LO write decode.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sgn_d   = sgn_q;
      cnt_d   = cnt_q;
      we_hi   = 1'b0;
      we_lo   = 1'b0;
      hi_wr   = '0;
      lo_wr   = '0;

      if (flush) begin
         // Abort wins over div_ready and cnt==0: nothing is written.
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (op_valid) begin
                  case (op_code)
                     OP_MULT, OP_MULTU: begin
                        opa_d   = src_a;
                        opb_d   = src_b;
                        sgn_d   = (op_code == OP_MULT);
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                        state_d = ST_MUL_WAIT;
                     end
                     OP_DIV, OP_DIVU: begin
                        if (src_b != '0) begin
                           opa_d   = src_a;
                           opb_d   = src_b;
                           sgn_d   = (op_code == OP_DIV);
                           state_d = ST_DIV_WAIT;
                        end else begin
                           // Divide by zero: HI/LO keep their values and
                           // the divider is never started.
                           state_d = ST_DONE;
                        end
                     end
                     OP_MTHI: begin
                        we_hi = 1'b1;
                        hi_wr = src_a;
                     end
                     OP_MTLO: begin
                        we_lo = 1'b1;
                        lo_wr = src_a;
                     end
                     default: ;
                  endcase
               end
            end

            ST_MUL_WAIT: begin
               if (cnt_q == '0) begin
                  we_hi   = 1'b1;
                  we_lo   = 1'b1;
                  hi_wr   = mul_result[63:32];
                  lo_wr   = mul_result[31:0];
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end

            ST_DIV_WAIT: begin
               if (div_ready) begin
                  we_hi   = 1'b1;
                  we_lo   = 1'b1;
                  hi_wr   = div_result[63:32];   // remainder
                  lo_wr   = div_result[31:0];    // quotient
                  state_d = ST_DONE;
               end
            end

            ST_DONE: begin
               // Wait for EX to actually advance before accepting a new op.
               if (!pipe_hold) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         sgn_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sgn_q   <= sgn_d;
         cnt_q   <= cnt_d;
      end
   end

   hilo_reg u_hilo_reg (
      .clk    (clk),
      .resetn (resetn),
      .we_hi  (we_hi),
      .we_lo  (we_lo),
      .hi_i   (hi_wr),
      .lo_i   (lo_wr),
      .hi_o   (hi_o),
      .lo_o   (lo_o)
   );

   // Resource controls are decoded from registered state and operands; each
   // unit sees zeros outside its own wait state.
   assign mul_signed = in_mul & sgn_q;
   assign mul_ina    = in_mul ? opa_q : '0;
   assign mul_inb    = in_mul ? opb_q : '0;

   assign div_start  = in_div;
   assign div_signed = in_div & sgn_q;
   assign div_op1    = in_div ? opa_q : '0;
   assign div_op2    = in_div ? opb_q : '0;
   assign div_annul  = in_div & flush;

   assign busy = ~in_idle;

   // Combinational so the issue cycle itself stalls; flush and reset force
   // it low so a squashed or reset op never holds EX.
   assign stallreq = resetn & ~flush &
                     ((in_idle & op_valid & (is_mul_op(op_code) | is_div_op(op_code)))
                      | in_mul | in_div);

endmodule
